vdic_alu_responder: RTL and testbench

Command-driven stack ALU that answers the test bench's word stream: it receives parity-protected data and command words, pushes operands onto a data stack, folds them when a command arrives, and queues a `{status, result}` response into an output FIFO. It is the responder end of the `operation_t` / `stat_t` protocol exercised by the lab tester and scoreboard, and it is meant to replace the black-box DUT in block-level benches.

---
 rtl/vdic_alu_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_vdic_alu_responder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdic_alu_responder.sv
// Stack ALU responder: parity-checked data/command words fold the operand stack
// into a {status, result} response that is queued in a small output FIFO.
//
// state | meaning
// IDLE  | accepting data and command words
// EXEC  | folding one stacked operand per cycle into the accumulator
// WRITE | pushing the response, then emptying the stack and sticky flags
module vdic_alu_responder #(
    parameter int STACK_DEPTH = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_cmd,
    input  logic [7:0]  in_data,
    input  logic        in_parity,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_status,
    output logic [15:0] out_result
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int FC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [7:0] CMD_NOP = 8'h00;
    localparam logic [7:0] CMD_AND = 8'h01;
    localparam logic [7:0] CMD_OR  = 8'h02;
    localparam logic [7:0] CMD_XOR = 8'h03;
    localparam logic [7:0] CMD_ADD = 8'h10;
    localparam logic [7:0] CMD_SUB = 8'h20;

    localparam logic [7:0] S_MISSING_DATA         = 8'h01;
    localparam logic [7:0] S_COMMAND_PARITY_ERROR = 8'h40;
    localparam logic [7:0] S_INVALID_COMMAND      = 8'h80;

    typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [7:0]        stack_q [STACK_DEPTH];
    logic [7:0]        stack_d [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [SP_W-1:0]   idx_q, idx_d;
    logic [7:0]        op_q, op_d;
    logic [15:0]       acc_q, acc_d;
    logic [7:0]        status_q, status_d;
    logic              dperr_q, dperr_d;
    logic              sovf_q, sovf_d;
    logic              fovf_q, fovf_d;
    logic [23:0]       fifo_q [FIFO_DEPTH];
    logic [23:0]       fifo_d [FIFO_DEPTH];
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic              out_valid_q, out_valid_d;

    logic              accept;
    logic              par_err;
    logic              cmd_known;
    logic [7:0]        operand;
    logic              fifo_wr;
    logic [23:0]       fifo_wdata;
    logic              pop;
    logic [FC_W-1:0]   cnt_mid;

    function automatic logic [15:0] fold(input logic [7:0] op, input logic [15:0] a,
                                         input logic [7:0] b);
        logic [15:0] bx;
        bx = {8'h00, b};
        case (op)
            CMD_AND: fold = a & bx;
            CMD_OR:  fold = a | bx;
            CMD_XOR: fold = a ^ bx;
            CMD_ADD: fold = a + bx;
            CMD_SUB: fold = a - bx;
            default: fold = a;
        endcase
    endfunction

    assign accept    = in_valid && in_ready_q;
    assign par_err   = ^{in_data, in_parity};
    assign cmd_known = in_data inside {CMD_NOP, CMD_AND, CMD_OR, CMD_XOR, CMD_ADD, CMD_SUB};

    always_comb begin
        operand = 8'h00;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (idx_q == SP_W'(i)) operand = stack_q[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        stack_d    = stack_q;
        sp_d       = sp_q;
        idx_d      = idx_q;
        op_d       = op_q;
        acc_d      = acc_q;
        status_d   = status_q;
        dperr_d    = dperr_q;
        sovf_d     = sovf_q;
        fifo_wr    = 1'b0;
        fifo_wdata = 24'h0;
        case (state_q)
            IDLE: begin
                if (accept && !in_cmd) begin
                    if (par_err) begin
                        dperr_d = 1'b1;
                    end else if (sp_q == SP_W'(STACK_DEPTH)) begin
                        sovf_d = 1'b1;
                    end else begin
                        for (int i = 0; i < STACK_DEPTH; i++) begin
                            if (sp_q == SP_W'(i)) stack_d[i] = in_data;
                        end
                        sp_d = sp_q + SP_W'(1);
                    end
                end else if (accept && in_cmd) begin
                    acc_d = 16'h0;
                    if (par_err) begin
                        status_d = S_COMMAND_PARITY_ERROR;
                        state_d  = WRITE;
                    end else if (!cmd_known) begin
                        status_d = S_INVALID_COMMAND;
                        state_d  = WRITE;
                    end else if (in_data == CMD_NOP) begin
                        acc_d = acc_q;
                    end else if (sp_q < SP_W'(2)) begin
                        status_d = S_MISSING_DATA;
                        state_d  = WRITE;
                    end else if (dperr_q || sovf_q) begin
                        status_d = {2'b00, dperr_q, 3'b000, sovf_q, 1'b0};
                        state_d  = WRITE;
                    end else begin
                        // operand 0 is loaded here; EXEC folds the remaining N-1
                        status_d = 8'h00;
                        op_d     = in_data;
                        acc_d    = {8'h00, stack_q[0]};
                        idx_d    = SP_W'(1);
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                acc_d = fold(op_q, acc_q, operand);
                idx_d = idx_q + SP_W'(1);
                if (idx_q == sp_q - SP_W'(1)) state_d = WRITE;
            end
            WRITE: begin
                fifo_wr    = 1'b1;
                fifo_wdata = {status_q | {5'b00000, fovf_q, 2'b00}, acc_q};
                sp_d       = '0;
                dperr_d    = 1'b0;
                sovf_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    // Shift-register FIFO: slot 0 is the head, vacated slots are zeroed so the
    // registered head reads 0 whenever the FIFO is empty.
    always_comb begin
        fifo_d = fifo_q;
        fovf_d = fovf_q;
        pop    = out_valid_q && out_ready;
        cnt_mid = fcnt_q;
        if (pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) fifo_d[i] = fifo_q[i + 1];
            fifo_d[FIFO_DEPTH - 1] = 24'h0;
            cnt_mid = fcnt_q - FC_W'(1);
        end
        fcnt_d = cnt_mid;
        if (fifo_wr) begin
            if (cnt_mid < FC_W'(FIFO_DEPTH)) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (cnt_mid == FC_W'(i)) fifo_d[i] = fifo_wdata;
                end
                fcnt_d = cnt_mid + FC_W'(1);
                fovf_d = 1'b0;
            end else begin
                fovf_d = 1'b1;
            end
        end
        out_valid_d = (fcnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= 8'h00;
            sp_q        <= '0;
            idx_q       <= '0;
            op_q        <= 8'h00;
            acc_q       <= 16'h0;
            status_q    <= 8'h00;
            dperr_q     <= 1'b0;
            sovf_q      <= 1'b0;
            fovf_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 24'h0;
            fcnt_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            stack_q     <= stack_d;
            sp_q        <= sp_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            status_q    <= status_d;
            dperr_q     <= dperr_d;
            sovf_q      <= sovf_d;
            fovf_q      <= fovf_d;
            fifo_q      <= fifo_d;
            fcnt_q      <= fcnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_status = fifo_q[0][23:16];
    assign out_result = fifo_q[0][15:0];

endmodule

// File: tb/tb_vdic_alu_responder.sv
// Bench for vdic_alu_responder: directed protocol cases plus random word streams,
// checked against a queue-based model of the stack, sticky flags and response FIFO.
module tb_vdic_alu_responder;
    localparam int STACK_DEPTH = 8;
    localparam int FIFO_DEPTH  = 4;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_AND = 8'h01;
    localparam logic [7:0] OP_OR  = 8'h02;
    localparam logic [7:0] OP_XOR = 8'h03;
    localparam logic [7:0] OP_ADD = 8'h10;
    localparam logic [7:0] OP_SUB = 8'h20;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_cmd;
    logic [7:0]  in_data;
    logic        in_parity;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_status;
    logic [15:0] out_result;

    always #5 clk = ~clk;

    vdic_alu_responder #(.STACK_DEPTH(STACK_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cmd     (in_cmd),
        .in_data    (in_data),
        .in_parity  (in_parity),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_status (out_status),
        .out_result (out_result)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // reference model state
    int          m_stk[$];
    bit          m_dperr, m_sovf, m_fovf;
    logic [23:0] exp_fifo[$];
    bit          pend;
    logic [23:0] pend_rsp;
    int          pend_lat;

    task automatic model_reset();
        m_stk.delete();
        exp_fifo.delete();
        m_dperr = 0; m_sovf = 0; m_fovf = 0; pend = 0;
    endtask

    task automatic model_word(input bit cmd, input logic [7:0] d, input bit bad);
        int acc;
        pend = 0;
        if (!cmd) begin
            if (bad) m_dperr = 1;
            else if (m_stk.size() == STACK_DEPTH) m_sovf = 1;
            else m_stk.push_back(int'(d));
        end else begin
            pend = 1;
            pend_lat = 1;
            if (bad) pend_rsp = {8'h40, 16'h0};
            else if (!(d inside {OP_NOP, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB})) pend_rsp = {8'h80, 16'h0};
            else if (d == OP_NOP) pend = 0;
            else if (m_stk.size() < 2) pend_rsp = {8'h01, 16'h0};
            else if (m_dperr || m_sovf) pend_rsp = {8'((m_dperr ? 32 : 0) | (m_sovf ? 2 : 0)), 16'h0};
            else begin
                acc = m_stk[0];
                for (int i = 1; i < m_stk.size(); i++) begin
                    case (d)
                        OP_ADD:  acc = (acc + m_stk[i]) % 65536;
                        OP_SUB:  acc = (acc - m_stk[i] + 65536) % 65536;
                        OP_AND:  acc = acc & m_stk[i];
                        OP_OR:   acc = acc | m_stk[i];
                        default: acc = acc ^ m_stk[i];
                    endcase
                end
                pend_rsp = {8'h00, 16'(acc)};
                pend_lat = m_stk.size();
            end
            if (pend) begin
                m_stk.delete();
                m_dperr = 0;
                m_sovf  = 0;
            end
        end
    endtask

    task automatic model_write(input bit popped);
        if (popped && exp_fifo.size() > 0) void'(exp_fifo.pop_front());
        if (exp_fifo.size() < FIFO_DEPTH) begin
            exp_fifo.push_back(pend_rsp | {5'b00000, m_fovf, 18'h0});
            m_fovf = 0;
        end else begin
            m_fovf = 1;
        end
    endtask

    // called and returns 1ns after a rising edge
    task automatic send_word(input bit cmd, input logic [7:0] d, input bit bad);
        int n = 0;
        in_cmd    = cmd;
        in_data   = d;
        in_parity = (^d) ^ bad;
        in_valid  = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_wait", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_word(cmd, d, bad);
    endtask

    task automatic push(input logic [7:0] d);
        send_word(1'b0, d, 1'b0);
    endtask

    task automatic run_cmd(input logic [7:0] op, input bit bad, input bit pop_at_write,
                           output int vlat);
        int n = 0;
        bit popped = 0;
        vlat = 0;
        send_word(1'b1, op, bad);
        if (pend) begin
            do begin
                if (pop_at_write && n == pend_lat - 1 && out_valid && exp_fifo.size() > 0) begin
                    chk("pop_head", {out_status, out_result}, exp_fifo[0]);
                    out_ready = 1'b1;
                    popped = 1;
                end
                @(posedge clk); #1;
                out_ready = 1'b0;
                n++;
                if (out_valid && vlat == 0) vlat = n;
            end while (!in_ready && n < 64);
            chk("latency", n, pend_lat);
            model_write(popped);
        end
    endtask

    task automatic expect_head(input logic [7:0] s, input logic [15:0] r);
        chk("head_status", out_status, s);
        chk("head_result", out_result, r);
    endtask

    task automatic drain();
        int exp_n = exp_fifo.size();
        int got = 0;
        while (out_valid && got <= FIFO_DEPTH) begin
            if (exp_fifo.size() == 0) begin
                chk("extra_rsp", 1, 0);
                break;
            end
            chk("rsp", {out_status, out_result}, exp_fifo[0]);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            void'(exp_fifo.pop_front());
            got++;
        end
        chk("drain_cnt", got, exp_n);
        chk("empty_out", {out_valid, out_status, out_result}, 0);
        exp_fifo.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int vl;
        logic [7:0] op;
        in_valid = 0; in_cmd = 0; in_data = 0; in_parity = 0; out_ready = 0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out", {out_valid, out_status, out_result}, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("rdy_after_rst", in_ready, 1);
        chk("out_after_rst", {out_valid, out_status, out_result}, 0);

        // arithmetic
        push(8'hFF); push(8'hFF); push(8'h03);
        run_cmd(OP_ADD, 0, 0, vl);
        chk("add_vlat", vl, 3);
        expect_head(8'h00, 16'h0201);
        drain();
        push(8'h01); push(8'h05);
        run_cmd(OP_SUB, 0, 0, vl);
        expect_head(8'h00, 16'hFFFC);
        drain();

        // logic
        push(8'hF0); push(8'h3C); run_cmd(OP_AND, 0, 0, vl);
        expect_head(8'h00, 16'h0030); drain();
        push(8'hF0); push(8'h3C); run_cmd(OP_XOR, 0, 0, vl);
        expect_head(8'h00, 16'h00CC); drain();
        push(8'hF0); push(8'h3C); run_cmd(OP_OR, 0, 0, vl);
        expect_head(8'h00, 16'h00FC); drain();

        // NOP between data words
        push(8'h07);
        run_cmd(OP_NOP, 0, 0, vl);
        @(posedge clk); #1;
        chk("nop_no_rsp", out_valid, 0);
        push(8'h09);
        run_cmd(OP_ADD, 0, 0, vl);
        expect_head(8'h00, 16'h0010); drain();

        // errors
        push(8'h05); run_cmd(OP_ADD, 0, 0, vl);
        expect_head(8'h01, 16'h0); drain();
        run_cmd(8'hFE, 0, 0, vl);
        expect_head(8'h80, 16'h0); drain();
        run_cmd(OP_ADD, 1, 0, vl);
        expect_head(8'h40, 16'h0); drain();
        send_word(1'b0, 8'h11, 1'b1); push(8'h22); push(8'h33);
        run_cmd(OP_ADD, 0, 0, vl);
        expect_head(8'h20, 16'h0); drain();

        // stack overflow
        for (int i = 1; i <= 9; i++) push(8'(i));
        run_cmd(OP_OR, 0, 0, vl);
        expect_head(8'h02, 16'h0); drain();

        // FIFO overflow: five responses, fifth dropped
        for (int i = 0; i < 5; i++) begin
            push(8'(i)); push(8'(i + 1));
            run_cmd(OP_ADD, 0, 0, vl);
        end
        expect_head(8'h00, 16'h0001);
        drain();
        push(8'h02); push(8'h03);
        run_cmd(OP_ADD, 0, 0, vl);
        expect_head(8'h04, 16'h0005);
        drain();

        // full FIFO with pop and write on the same edge
        for (int i = 0; i < 4; i++) begin
            push(8'(16 * i)); push(8'h01);
            run_cmd(OP_ADD, 0, 0, vl);
        end
        push(8'h40); push(8'h01);
        run_cmd(OP_SUB, 0, 1, vl);
        expect_head(8'h00, 16'h0011);
        drain();

        // reset during EXEC aborts the response
        push(8'h01); push(8'h02); push(8'h03);
        send_word(1'b1, OP_ADD, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        model_reset();
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_rsp", out_valid, 0);
        chk("abort_ready", in_ready, 1);
        run_cmd(OP_ADD, 0, 0, vl);
        expect_head(8'h01, 16'h0);
        drain();

        // random streams
        for (int it = 0; it < 60; it++) begin
            int nd = $urandom_range(0, 10);
            for (int j = 0; j < nd; j++)
                send_word(1'b0, 8'($urandom), $urandom_range(0, 15) == 0);
            case ($urandom_range(0, 7))
                0: op = OP_NOP;
                1: op = OP_AND;
                2: op = OP_OR;
                3: op = OP_XOR;
                4: op = OP_SUB;
                5: op = 8'($urandom);
                default: op = OP_ADD;
            endcase
            run_cmd(op, $urandom_range(0, 19) == 0, 0, vl);
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
